// File: rtl/rep_add_mult.sv
// rep_add_mult: repeated-addition multiplier.
// Computes product = a * b (modulo 2^PW) by adding the captured multiplicand
// to an accumulator once per cycle while a down-counter loaded with b is
// non-zero. Start/busy/done handshake toward the surrounding control logic.
//
// Handshake: start is sampled only in IDLE; the accepting edge captures a and
// b. busy is high from the cycle after that edge through the DONE cycle, and
// done pulses for exactly one cycle with product final. start while busy is
// ignored (no queuing).
//
// Optional feature (macro MULT_OVF_EN): adds the sticky ovf output, set when
// any accumulation step carries out of PW bits and cleared on the next
// accepted start. Without the macro the product silently wraps.
module rep_add_mult #(
   parameter int WIDTH = 16,
   parameter int PW    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [PW-1:0]    product,
   output logic             busy,
`ifdef MULT_OVF_EN
   output logic             done,
   output logic             ovf
`else
   output logic             done
`endif
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADD  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_reg_q, a_reg_d;
   logic [WIDTH-1:0] cnt_q,   cnt_d;
   logic [PW-1:0]    product_q, product_d;
   logic             busy_q,  busy_d;
   logic             done_q,  done_d;
   logic             cnt_zero;

`ifdef MULT_OVF_EN
   logic             ovf_q, ovf_d;
   // One extra bit holds the carry out of the accumulator.
   logic [PW:0]      sum;
`else
   logic [PW-1:0]    sum;
`endif

   // Zero detect on the internal counter only; decides ADD vs. DONE.
   assign cnt_zero = (cnt_q == '0);

   // Next-state, datapath and registered-output computation.
   always_comb begin
      state_d   = state_q;
      a_reg_d   = a_reg_q;
      cnt_d     = cnt_q;
      product_d = product_q;
`ifdef MULT_OVF_EN
      ovf_d     = ovf_q;
      sum       = {1'b0, product_q} + (PW+1)'(a_reg_q);
`else
      sum       = product_q + PW'(a_reg_q);
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_reg_d   = a;
               cnt_d     = b;
               product_d = '0;
`ifdef MULT_OVF_EN
               ovf_d     = 1'b0;
`endif
               state_d   = S_ADD;
            end
         end
         S_ADD: begin
            if (cnt_zero) begin
               state_d = S_DONE;
            end else begin
               product_d = sum[PW-1:0];
               cnt_d     = cnt_q - WIDTH'(1);
`ifdef MULT_OVF_EN
               if (sum[PW]) ovf_d = 1'b1;
`endif
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      // Outputs are registered from the next state so they line up with it.
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   // Single state/datapath register bank; reset aborts any operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         a_reg_q   <= '0;
         cnt_q     <= '0;
         product_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef MULT_OVF_EN
         ovf_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         a_reg_q   <= a_reg_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
`ifdef MULT_OVF_EN
         ovf_q     <= ovf_d;
`endif
      end
   end

   assign product = product_q;
   assign busy    = busy_q;
   assign done    = done_q;
`ifdef MULT_OVF_EN
   assign ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_rep_add_mult.sv
// tb_rep_add_mult: self-checking bench for rep_add_mult (WIDTH=16, PW=16).
// Expected results come from plain multiplication of the applied operands;
// ovf is checked only when MULT_OVF_EN is defined.
module tb_rep_add_mult;

   localparam int WIDTH = 16;
   localparam int PW    = 16;
   localparam int EW    = PW + 1;   // {ovf, product}

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic [PW-1:0]    product;
   logic             busy;
   logic             done;
`ifdef MULT_OVF_EN
   logic             ovf;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int done_cnt = 0;

   logic [EW-1:0] exp_q[$];

   rep_add_mult #(.WIDTH(WIDTH), .PW(PW)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .a       (a_in),
      .b       (b_in),
      .product (product),
      .busy    (busy),
`ifdef MULT_OVF_EN
      .done    (done),
      .ovf     (ovf)
`else
      .done    (done)
`endif
   );

   // Clock and reset.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Reference: true product, then wrap to PW bits; overflow means the true
   // product does not fit (partial sums only grow, so any step overflowing
   // is the same as the final one not fitting).
   function automatic logic [EW-1:0] model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
      longint unsigned p;
      logic [PW-1:0] prod;
      logic          o;
      p    = longint'(av) * longint'(bv);
      prod = PW'(p % (longint'(1) << PW));
      o    = (p >= (longint'(1) << PW));
      return {o, prod};
   endfunction

   // Scoreboard: every done pulse consumes one expected result.
   always @(negedge clk) begin
      if (rst_n && done) begin
         logic [EW-1:0] e;
         done_cnt++;
         if (exp_q.size() == 0) begin
            check("unexpected_done", 64'd1, 64'd0);
         end else begin
            e = exp_q.pop_front();
            check("product", 64'(product), 64'(e[PW-1:0]));
`ifdef MULT_OVF_EN
            check("ovf", 64'(ovf), 64'(e[PW]));
`endif
         end
      end
   end

   // Wait (from a negedge) for done, counting negedges; bounded.
   task automatic wait_done(input int bound, output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!done && cyc < bound);
      if (!done) check("done_timeout", 64'd0, 64'd1);
   endtask

   // Driver: one operation, start pulsed for one edge; checks latency/busy.
   task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
      int  cyc;
      bit  busy_bad;
      exp_q.push_back(model(av, bv));
      start = 1'b1;
      a_in  = av;
      b_in  = bv;
      @(posedge clk);
      #1;
      start = 1'b0;
      a_in  = WIDTH'($urandom);
      b_in  = WIDTH'($urandom);
      busy_bad = 1'b0;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (!busy) busy_bad = 1'b1;
      end while (!done && cyc < int'(bv) + 10);
      check("latency", 64'(cyc), 64'(int'(bv) + 2));
      check("busy_during_op", 64'(busy_bad), 64'd0);
      @(negedge clk);
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_done", 64'(done), 64'd0);
      check("idle_hold", 64'(product), 64'(model(av, bv) & {1'b0, {PW{1'b1}}}));
   endtask

   initial begin
      int c1, c2, d0;
      rst_n = 1'b0;
      start = 1'b0;
      a_in  = '0;
      b_in  = '0;
      repeat (3) @(negedge clk);
      check("rst_product", 64'(product), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
`ifdef MULT_OVF_EN
      check("rst_ovf", 64'(ovf), 64'd0);
`endif
      rst_n = 1'b1;
      @(negedge clk);

      // Directed cases.
      run_op(16'd7, 16'd3);
      run_op(16'd9, 16'd0);
      run_op(16'd0, 16'd4);
      run_op(16'hFFFF, 16'd1);
      run_op(16'h8000, 16'd3);
      run_op(16'd1, 16'd1);

      // Start while busy is ignored.
      d0 = done_cnt;
      exp_q.push_back(model(16'd2, 16'd5));
      start = 1'b1; a_in = 16'd2; b_in = 16'd5;
      @(posedge clk); #1; start = 1'b0;
      @(negedge clk); @(negedge clk);
      start = 1'b1; a_in = 16'd3; b_in = 16'd3;
      @(posedge clk); #1; start = 1'b0;
      wait_done(20, c1);
      repeat (6) @(negedge clk);
      check("ignored_start_dones", 64'(done_cnt - d0), 64'd1);
      check("ignored_start_prod", 64'(product), 64'd10);
      check("ignored_start_idle", 64'(busy), 64'd0);

      // Back-to-back with start held high; inputs changed during DONE.
      exp_q.push_back(model(16'd1, 16'd1));
      start = 1'b1; a_in = 16'd1; b_in = 16'd1;
      wait_done(10, c1);
      check("b2b_lat1", 64'(c1), 64'd3);
      a_in = 16'd4; b_in = 16'd2;
      exp_q.push_back(model(16'd4, 16'd2));
      wait_done(12, c2);
      check("b2b_gap", 64'(c2), 64'd5);
      start = 1'b0;
      @(negedge clk); @(negedge clk);

      // Randomized operations.
      for (int i = 0; i < 25; i++) begin
         run_op(WIDTH'($urandom), WIDTH'($urandom_range(0, 12)));
      end

      // Asynchronous reset mid-ADD, no done afterwards.
      start = 1'b1; a_in = 16'd5; b_in = 16'd10;
      @(posedge clk); #1; start = 1'b0;
      repeat (4) @(negedge clk);
      #2;
      d0 = done_cnt;
      rst_n = 1'b0;
      #1;
      check("arst_product", 64'(product), 64'd0);
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_done", 64'(done), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (16) @(negedge clk);
      check("arst_no_done", 64'(done_cnt - d0), 64'd0);

      // One more op after reset recovers normally.
      run_op(16'd3, 16'd2);

      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
